// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage floating-point add/subtract (align, add, normalise) with valid/ready flow.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_addsub_pipe #(
  parameter int EW = 8,
  parameter int MW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          op,
  input  logic          a_s,
  input  logic [EW-1:0] a_e,
  input  logic [MW-1:0] a_m,
  input  logic          b_s,
  input  logic [EW-1:0] b_e,
  input  logic [MW-1:0] b_m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [MW-1:0] out_m,
  output logic          out_ovf
);
  localparam int FW   = MW + 3;  // aligned field: mantissa, guard, round, sticky
  localparam int EMAX = (1 << EW) - 1;

  function automatic int lzc(input logic [FW-1:0] v);
    lzc = FW;
    for (int i = 0; i < FW; i++)
      if (v[i]) lzc = FW - 1 - i;
  endfunction

  logic          advance;
  logic          s1_valid_q, s1_byp_q, s1_sub_q, s1_sign_q;
  logic [EW-1:0] s1_e_q;
  logic [MW-1:0] s1_ml_q;
  logic [FW-1:0] s1_ms_q;
  logic          s2_valid_q, s2_byp_q, s2_sign_q;
  logic [EW-1:0] s2_e_q;
  logic [FW:0]   s2_sum_q;
  logic          out_valid_q, out_s_q, out_ovf_q;
  logic [EW-1:0] out_e_q;
  logic [MW-1:0] out_m_q;

  assign advance   = !out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_e     = out_e_q;
  assign out_m     = out_m_q;
  assign out_ovf   = out_ovf_q;

  // Stage 1: pick the larger magnitude and align the smaller one with sticky collection.
  logic          b_eff_s, a_larger, a_zero, b_zero;
  logic          s1_byp_d, s1_sub_d, s1_sign_d;
  logic [EW-1:0] s1_e_d, diff;
  logic [MW-1:0] s1_ml_d, m_small;
  logic [FW-1:0] s1_ms_d, ext, dropped;

  // NOTE: every always_comb output gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    b_eff_s   = b_s ^ op;
    a_zero    = (a_m == '0);
    b_zero    = (b_m == '0);
    a_larger  = {a_e, a_m} >= {b_e, b_m};
    s1_sub_d  = a_s ^ b_eff_s;
    s1_sign_d = a_larger ? a_s : b_eff_s;
    s1_e_d    = a_larger ? a_e : b_e;
    s1_ml_d   = a_larger ? a_m : b_m;
    m_small   = a_larger ? b_m : a_m;
    diff      = a_larger ? a_e - b_e : b_e - a_e;
    ext       = {m_small, 3'b000};
    dropped   = '0;
    if (int'(diff) >= FW) begin
      s1_ms_d = {{(FW-1){1'b0}}, |m_small};
    end else begin
      dropped = ext & ~({FW{1'b1}} << diff);
      s1_ms_d = (ext >> diff) | {{(FW-1){1'b0}}, |dropped};
    end
    s1_byp_d = a_zero | b_zero;
    if (a_zero && b_zero) begin
      s1_sign_d = 1'b0;
      s1_e_d    = '0;
      s1_ml_d   = '0;
    end else if (a_zero) begin
      s1_sign_d = b_eff_s;
      s1_e_d    = b_e;
      s1_ml_d   = b_m;
    end else if (b_zero) begin
      s1_sign_d = a_s;
      s1_e_d    = a_e;
      s1_ml_d   = a_m;
    end
  end

  // Stage 2: magnitude add/subtract; larger minus smaller never goes negative.
  logic [FW:0] s2_sum_d;
  always_comb begin
    if (s1_byp_q)      s2_sum_d = {1'b0, s1_ml_q, 3'b000};
    else if (s1_sub_q) s2_sum_d = {1'b0, s1_ml_q, 3'b000} - {1'b0, s1_ms_q};
    else               s2_sum_d = {1'b0, s1_ml_q, 3'b000} + {1'b0, s1_ms_q};
  end

  // Stage 3: normalise, round, then classify overflow / underflow / zero.
  int            lz, e_n;
  logic [FW-1:0] norm;
  logic [MW-1:0] m_rnd;
  logic          out_s_d, out_ovf_d;
  logic [EW-1:0] out_e_d;
  logic [MW-1:0] out_m_d;
`ifdef FP_ADDSUB_RNE_EN
  logic [MW:0]   mant;
`endif

  always_comb begin
    lz = lzc(s2_sum_q[FW-1:0]);
    if (s2_sum_q[FW]) begin
      norm = {s2_sum_q[FW:2], s2_sum_q[1] | s2_sum_q[0]};
      e_n  = int'(s2_e_q) + 1;
    end else begin
      norm = s2_sum_q[FW-1:0] << lz;
      e_n  = int'(s2_e_q) - lz;
    end
`ifdef FP_ADDSUB_RNE_EN
    mant = {1'b0, norm[FW-1:3]} + {{MW{1'b0}}, norm[2] & (norm[1] | norm[0] | norm[3])};
    if (mant[MW]) begin
      mant = mant >> 1;
      e_n  = e_n + 1;
    end
    m_rnd = mant[MW-1:0];
`else
    m_rnd = MW'(norm >> 3);
`endif
    out_s_d   = s2_sign_q;
    out_e_d   = e_n[EW-1:0];
    out_m_d   = m_rnd;
    out_ovf_d = 1'b0;
    if (s2_byp_q) begin
      out_e_d = s2_e_q;
      out_m_d = s2_sum_q[FW-1:3];
    end else if (s2_sum_q == '0 || e_n < 1) begin
      out_s_d = 1'b0;
      out_e_d = '0;
      out_m_d = '0;
    end else if (e_n >= EMAX) begin
      out_e_d   = '1;
      out_m_d   = '0;
      out_ovf_d = 1'b1;
    end
  end

  // NOTE: datapath stage registers carry no reset; their valid bits alone decide whether they matter.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_byp_q  <= s1_byp_d;
      s1_sub_q  <= s1_sub_d;
      s1_sign_q <= s1_sign_d;
      s1_e_q    <= s1_e_d;
      s1_ml_q   <= s1_ml_d;
      s1_ms_q   <= s1_ms_d;
    end
    if (advance && s1_valid_q) begin
      s2_byp_q  <= s1_byp_q;
      s2_sign_q <= s1_sign_q;
      s2_e_q    <= s1_e_q;
      s2_sum_q  <= s2_sum_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_m_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_s_q   <= out_s_d;
        out_e_q   <= out_e_d;
        out_m_q   <= out_m_d;
        out_ovf_q <= out_ovf_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe: exact-arithmetic reference model, scoreboard and directed vectors.
// Build with the same FP_ADDSUB_RNE_EN setting as the design.
module tb_fp_addsub_pipe;
  localparam int EW = 8;
  localparam int MW = 24;

  typedef struct packed {
    logic        o;
    logic        as;
    logic [7:0]  ae;
    logic [23:0] am;
    logic        bs;
    logic [7:0]  be;
    logic [23:0] bm;
    logic [33:0] exp;  // {s, e, m, ovf}
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, op, a_s, b_s;
  logic [EW-1:0] a_e, b_e;
  logic [MW-1:0] a_m, b_m;
  logic          out_valid, out_ready, out_s, out_ovf;
  logic [EW-1:0] out_e;
  logic [MW-1:0] out_m;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_out = 0;
  logic [33:0]   exp_q[$];
  vec_t          vec[14];
  logic [33:0]   snap;

  fp_addsub_pipe #(.EW(EW), .MW(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_s(a_s), .a_e(a_e), .a_m(a_m),
    .b_s(b_s), .b_e(b_e), .b_m(b_m),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_m(out_m), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Exact sum on a wide integer grid, then rounded and classified.
  function automatic logic [33:0] model(input logic o, input logic as, input logic [7:0] ae,
                                        input logic [23:0] am, input logic bs, input logic [7:0] be,
                                        input logic [23:0] bm);
    logic [319:0] va, vb, mag;
`ifdef FP_ADDSUB_RNE_EN
    logic [319:0] rem, half;
`endif
    logic [24:0]  m;
    logic         s, bse;
    int           emin, p, e, sh;
    bse = bs ^ o;
    if (am == 0 && bm == 0) return '0;
    if (am == 0) return {bse, be, bm, 1'b0};
    if (bm == 0) return {as, ae, am, 1'b0};
    emin = (ae < be) ? int'(ae) : int'(be);
    va = 320'(am) << (int'(ae) - emin);
    vb = 320'(bm) << (int'(be) - emin);
    if (as == bse)     begin mag = va + vb; s = as;  end
    else if (va >= vb) begin mag = va - vb; s = as;  end
    else               begin mag = vb - va; s = bse; end
    if (mag == 0) return '0;
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = emin + p - (MW - 1);
    if (p > MW - 1) begin
      sh = p - (MW - 1);
      m  = 25'(mag >> sh);
`ifdef FP_ADDSUB_RNE_EN
      rem  = mag & ((320'd1 << sh) - 320'd1);
      half = 320'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 25'd1;
      if (m[24]) begin m = m >> 1; e = e + 1; end
`endif
    end else begin
      m = 25'(mag << (MW - 1 - p));
    end
    if (e >= 255) return {s, 8'hFF, 24'h0, 1'b1};
    if (e < 1) return '0;
    return {s, 8'(e), m[23:0], 1'b0};
  endfunction

  function automatic vec_t mk(input logic o, input logic as, input logic [7:0] ae, input logic [23:0] am,
                              input logic bs, input logic [7:0] be, input logic [23:0] bm,
                              input logic es, input logic [7:0] ee, input logic [23:0] em, input logic eo);
    return '{o, as, ae, am, bs, be, bm, {es, ee, em, eo}};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input int i);
    int n;
    in_valid = 1'b1;
    op = vec[i].o;
    a_s = vec[i].as; a_e = vec[i].ae; a_m = vec[i].am;
    b_s = vec[i].bs; b_e = vec[i].be; b_m = vec[i].bm;
    n = 0;
    forever begin
      #4;
      if (in_ready) begin
        exp_q.push_back(model(vec[i].o, vec[i].as, vec[i].ae, vec[i].am, vec[i].bs, vec[i].be, vec[i].bm));
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input int i);
    int lat;
    send(i);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    check("lat_result", {out_s, out_e, out_m, out_ovf}, vec[i].exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: compare each transferred result, just before the rising edge that transfers it.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", {out_s, out_e, out_m, out_ovf}, e);
          n_out++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    vec[0]  = mk(0, 0, 127, 24'h800000, 0, 127, 24'h800000, 0, 128, 24'h800000, 0);
    vec[1]  = mk(1, 0, 127, 24'h800000, 0, 127, 24'h800000, 0, 0, 24'h000000, 0);
`ifdef FP_ADDSUB_RNE_EN
    vec[2]  = mk(0, 0, 127, 24'h800001, 0, 103, 24'h800000, 0, 127, 24'h800002, 0);
    vec[13] = mk(1, 0, 127, 24'h800000, 0, 60, 24'h800000, 0, 127, 24'h800000, 0);
`else
    vec[2]  = mk(0, 0, 127, 24'h800001, 0, 103, 24'h800000, 0, 127, 24'h800001, 0);
    vec[13] = mk(1, 0, 127, 24'h800000, 0, 60, 24'h800000, 0, 126, 24'hFFFFFF, 0);
`endif
    vec[3]  = mk(0, 0, 127, 24'h800000, 0, 103, 24'h800000, 0, 127, 24'h800000, 0);
    vec[4]  = mk(0, 0, 254, 24'hFFFFFF, 0, 254, 24'hFFFFFF, 0, 255, 24'h000000, 1);
    vec[5]  = mk(1, 0, 127, 24'hC00000, 0, 127, 24'h800000, 0, 126, 24'h800000, 0);
    vec[6]  = mk(1, 0, 127, 24'h800000, 0, 128, 24'h800000, 1, 127, 24'h800000, 0);
    vec[7]  = mk(1, 0, 50, 24'h000000, 0, 100, 24'hABCDEF, 1, 100, 24'hABCDEF, 0);
    vec[8]  = mk(0, 1, 10, 24'h000000, 1, 20, 24'h000000, 0, 0, 24'h000000, 0);
    vec[9]  = mk(1, 0, 1, 24'h800000, 0, 1, 24'hC00000, 0, 0, 24'h000000, 0);
    vec[10] = mk(0, 0, 200, 24'h800000, 0, 10, 24'hFFFFFF, 0, 200, 24'h800000, 0);
    vec[11] = mk(0, 1, 127, 24'h800000, 1, 127, 24'h800000, 1, 128, 24'h800000, 0);
    vec[12] = mk(0, 0, 128, 24'hC00000, 1, 127, 24'h800000, 0, 128, 24'h800000, 0);

    rst_n = 1'b1; in_valid = 1'b0; op = 1'b0; out_ready = 1'b1;
    a_s = 1'b0; a_e = '0; a_m = '0; b_s = 1'b0; b_e = '0; b_m = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_fields", {out_s, out_e, out_m, out_ovf}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #4 check("in_ready_after_reset", in_ready, 1);
    @(negedge clk);

    // Pin the reference model against hand-computed results.
    for (int i = 0; i < 14; i++)
      check($sformatf("model_pin_%0d", i),
            model(vec[i].o, vec[i].as, vec[i].ae, vec[i].am, vec[i].bs, vec[i].be, vec[i].bm), vec[i].exp);

    lat_check(0);
    for (int i = 1; i < 14; i++) send(i);
    drain();

    // Backpressure: four back-to-back ops, out_ready low for 5 cycles from the first out_valid.
    n0 = n_out;
    fork
      begin
        send(5); send(6); send(11); send(12);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        out_ready = 1'b0;
        snap = {out_s, out_e, out_m, out_ovf};
        repeat (5) begin
          #4;
          check("stall_in_ready", in_ready, 0);
          check("stall_hold", {out_s, out_e, out_m, out_ovf, out_valid}, {snap, 1'b1});
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_delivered", n_out - n0, 4);

    // Reset with two ops in flight: everything discarded, next op still has 3-cycle latency.
    send(0); send(3);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    check("rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fields", {out_s, out_e, out_m, out_ovf}, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      #4 check("rst_no_stale", out_valid, 0);
      @(negedge clk);
    end
    lat_check(12);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, pipelined floating-point adder/subtractor with a valid/ready handshake and a per-transaction add/subtract select. Operands and result use the split sign / biased exponent / explicit-hidden-bit mantissa format of the DCT datapath. The block sits between the DCT multiplier outputs and the accumulation stage, replacing combinational float addition so that the multiply-accumulate path can be clocked at full rate.

## Interface
- EW, 8, exponent width (biased, unsigned)
- MW, 24, mantissa width including explicit leading 1; mantissa==0 encodes zero regardless of exponent
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operands this cycle
- op  in  1  0: a+b, 1: a−b
- a_s, b_s  in  1 each  operand signs
- a_e, b_e  in  EW each  operand exponents
- a_m, b_m  in  MW each  operand mantissas
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_s  out  1  result sign
- out_e  out  EW  result exponent
- out_m  out  MW  result mantissa, normalised (bit MW−1 set) unless zero
- out_ovf  out  1  exponent overflow on this result

## Operation
- Effective sign of b = b_s ^ op; effective subtraction when a_s != effective b sign.
- Stage 1 (align): larger-magnitude operand selected by exponent, then mantissa on equal exponents. Smaller mantissa right-shifted by the exponent difference into an MW+3-bit field (guard, round, sticky). Sticky = OR of all shifted-out bits. Shift ≥ MW+3 leaves only the sticky bit.
- Stage 2 (add): MW+4-bit magnitude add or subtract (larger − smaller, never negative). Result sign = sign of the larger operand.
- Stage 3 (normalise/round): carry-out shifts right 1, exponent +1, sticky absorbs the dropped bit. Otherwise a leading-zero count drives a left shift, and the exponent is decremented by that count. Rounding is applied per Configuration; a rounding carry renormalises and increments the exponent.
- Zero operand: the other operand passes through exactly, with its effective sign.
- Exact cancellation or both operands zero: out_s=0, out_e=0, out_m=0.
- Exponent result ≥ 2^EW−1: out_e=all ones, out_m=0, out_ovf=1, sign kept.
- Exponent result < 1 after normalisation: flush to zero (s=0, e=0, m=0), out_ovf=0.
- Handshake: advance = !out_valid | out_ready; in_ready = advance. When advance is 0, all stage registers and outputs hold. Transfers occur on in_valid&in_ready and out_valid&out_ready. Order is preserved; no transaction is dropped or duplicated.

## Timing
- Latency 3 cycles, accept-to-out_valid, with no backpressure. Throughput is 1 per cycle.
- Per-stage valid bits; bubbles propagate as invalid stages and do not block acceptance.
- in_ready is combinational from out_valid/out_ready only; there is no path from in_valid to in_ready.
- Outputs are registered; they are stable while out_valid=1 and out_ready=0.
- Reset (async assert, sync-to-clk deassert by the system): all stage valids 0, out_valid=0, out_s=0, out_e=0, out_m=0, out_ovf=0. Reset asserted mid-operation discards all in-flight transactions. in_ready=1 from the first cycle after reset.

## Configuration
- FP_ADDSUB_RNE_EN defined: round-to-nearest-even on G/R/S. Round up if G&(R|S|lsb).
- FP_ADDSUB_RNE_EN undefined: truncation (round toward zero). G/R/S are discarded, the rounding incrementer and renormalisation are removed, and latency is unchanged.

## Test plan
- EW=8, MW=24, out_ready=1: a=(0,127,0x800000), b=(0,127,0x800000), op=0 -> 3 cycles later (0,128,0x800000), out_ovf=0.
- Same operands, op=1 -> (0,0,0x000000).
- a=(0,127,0x800001), b=(0,103,0x800000), op=0 (exact tie, lsb 1) -> with RNE (0,127,0x800002); without RNE (0,127,0x800001). a_m=0x800000 with the same b -> (0,127,0x800000) in both builds.
- a=(0,254,0xFFFFFF), b=(0,254,0xFFFFFF), op=0 -> (0,255,0x000000), out_ovf=1.
- Stream 4 back-to-back ops with out_ready held low for 5 cycles from the first out_valid -> in_ready low while stalled, output held constant, all 4 results delivered in issue order, none lost.
- Pulse rst_n low while 2 ops are in flight -> out_valid=0 immediately. The next accepted op appears exactly 3 cycles after acceptance, with no stale result.
